// File: rtl/seq_alu.sv
// seq_alu: ALU with a valid/ready handshake. Single-cycle ops finish in one
// cycle. MUL/DIVU/REMU take WIDTH iterations: shift-add multiply or
// restoring divide. The result is held in DONE until the consumer takes it.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             ovf
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010, OP_SUB  = 4'b0011,
    OP_SLT  = 4'b0100, OP_SLL  = 4'b0101, OP_SRL  = 4'b0110, OP_SRA  = 4'b0111,
    OP_SLTU = 4'b1000, OP_XOR  = 4'b1001, OP_NOR  = 4'b1010, OP_MUL  = 4'b1011,
    OP_DIVU = 4'b1100, OP_REMU = 4'b1101, OP_RSV  = 4'b1110, OP_NOP  = 4'b1111
  } op_t;

  state_t           state, state_nx;
  op_t              op_q;
  logic             armed;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc, opa, opb;
  logic [WIDTH-1:0] acc_nx, opa_nx, opb_nx, multi_res;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] res_single, sum, dif;
  logic             ovf_single;
  logic             accept, is_multi, last_iter;

  // in_ready stays low until the first edge after reset is released
  assign in_ready  = armed && (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign is_multi  = (sel == OP_MUL) || (sel == OP_DIVU) || (sel == OP_REMU);
  assign last_iter = (cnt == SHW'(WIDTH - 1));

  // Single-cycle result and ADD/SUB overflow, computed from the live inputs
  always_comb begin
    res_single = '0;
    ovf_single = 1'b0;
    sum        = data_1 + data_2;
    dif        = data_1 - data_2;
    case (op_t'(sel))
      OP_AND:  res_single = data_1 & data_2;
      OP_OR:   res_single = data_1 | data_2;
      OP_ADD: begin
        res_single = sum;
        ovf_single = (data_1[MSB] == data_2[MSB]) && (sum[MSB] != data_1[MSB]);
      end
      OP_SUB: begin
        res_single = dif;
        ovf_single = (data_1[MSB] != data_2[MSB]) && (dif[MSB] != data_1[MSB]);
      end
      OP_SLT:  res_single = WIDTH'($signed(data_1) < $signed(data_2));
      OP_SLL:  res_single = data_2 << shamt;
      OP_SRL:  res_single = data_2 >> shamt;
      OP_SRA:  res_single = $unsigned($signed(data_2) >>> shamt);
      OP_SLTU: res_single = WIDTH'(data_1 < data_2);
      OP_XOR:  res_single = data_1 ^ data_2;
      OP_NOR:  res_single = ~(data_1 | data_2);
      default: res_single = '0;
    endcase
  end

  // One iteration step. For multiply, acc accumulates the product, opa is the
  // shifting multiplicand and opb the shifting multiplier. For divide, acc is
  // the partial remainder and opa shifts dividend bits out and quotient bits
  // in. A zero divisor always "fits", which yields an all-ones quotient and
  // leaves the dividend as the remainder.
  always_comb begin
    acc_nx = acc;
    opa_nx = opa;
    opb_nx = opb;
    trial  = '0;
    if (op_q == OP_MUL) begin
      acc_nx = acc + (opb[0] ? opa : '0);
      opa_nx = opa << 1;
      opb_nx = opb >> 1;
    end else begin
      trial = {acc, opa[MSB]};
      if (trial >= {1'b0, opb}) begin
        acc_nx = trial[WIDTH-1:0] - opb;
        opa_nx = {opa[MSB-1:0], 1'b1};
      end else begin
        acc_nx = trial[WIDTH-1:0];
        opa_nx = {opa[MSB-1:0], 1'b0};
      end
    end
    multi_res = (op_q == OP_DIVU) ? opa_nx : acc_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = is_multi ? BUSY : DONE;
      BUSY:    if (last_iter) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register, operand capture, iteration and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      armed   <= 1'b0;
      op_q    <= OP_AND;
      cnt     <= '0;
      acc     <= '0;
      opa     <= '0;
      opb     <= '0;
      alu_out <= '0;
      zero    <= 1'b1;
      ovf     <= 1'b0;
    end else begin
      armed <= 1'b1;
      state <= state_nx;
      case (state)
        IDLE: if (accept) begin
          op_q <= op_t'(sel);
          cnt  <= '0;
          acc  <= '0;
          opa  <= data_1;
          opb  <= data_2;
          if (!is_multi) begin
            alu_out <= res_single;
            zero    <= (res_single == '0);
            ovf     <= ovf_single;
          end
        end
        BUSY: begin
          acc <= acc_nx;
          opa <= opa_nx;
          opb <= opb_nx;
          if (last_iter) begin
            alu_out <= multi_res;
            zero    <= (multi_res == '0);
            ovf     <= 1'b0;
          end else begin
            cnt <= cnt + SHW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu (WIDTH=32): directed vector table, handshake corner
// sequences, and randomized ops against an arithmetic reference model.
module tb_seq_alu;
  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    sel = '0;
  logic [W-1:0]  data_1 = '0, data_2 = '0;
  logic [SW-1:0] shamt = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  alu_out;
  logic          zero, ovf;

  int n_cmp = 0;
  int n_err = 0;

  seq_alu #(.WIDTH(W), .SHW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .data_1(data_1), .data_2(data_2), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
    .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]    op;
    logic [W-1:0]  a, b;
    logic [SW-1:0] sh;
    logic [W-1:0]  res;
    logic          ovf;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference built from the opcode definitions with wide arithmetic
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, b,
                                input logic [SW-1:0] sh, output logic [W-1:0] r, output logic o);
    longint sa, sb, s;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    o = 1'b0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  begin s = sa + sb; r = W'(s); o = (s != longint'($signed(r))); end
      4'd3:  begin s = sa - sb; r = W'(s); o = (s != longint'($signed(r))); end
      4'd4:  r = (sa < sb) ? 1 : 0;
      4'd5:  r = b << sh;
      4'd6:  r = b >> sh;
      4'd7:  r = W'(sb >>> sh);
      4'd8:  r = (a < b) ? 1 : 0;
      4'd9:  r = a ^ b;
      4'd10: r = ~(a | b);
      4'd11: begin p = {32'b0, a} * {32'b0, b}; r = p[W-1:0]; end
      4'd12: r = (b == 0) ? '1 : a / b;
      4'd13: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op);
    return (op == 4'd11 || op == 4'd12 || op == 4'd13) ? W + 1 : 1;
  endfunction

  // Issue one request and wait for out_valid. lat counts edges from the
  // accepting edge (inclusive) to the first cycle with out_valid high.
  task automatic do_op(input logic [3:0] s, input logic [W-1:0] a, b, input logic [SW-1:0] sh,
                       output logic [W-1:0] r, output logic o, output logic z,
                       output int lat, output bit rdy_in_busy);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    sel = s; data_1 = a; data_2 = b; shamt = sh; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sel = 4'($urandom); data_1 = $urandom; data_2 = $urandom; shamt = SW'($urandom);
    lat = 1;
    rdy_in_busy = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_in_busy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    r = alu_out; o = ovf; z = zero;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] r, er, held;
    logic o, z, eo;
    int lat;
    bit rb, stable, seen;
    logic [3:0] op;
    logic [W-1:0] a, b;
    logic [SW-1:0] sh;

    vecs[0]  = '{4'h2, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b1};
    vecs[1]  = '{4'hB, 32'h00010000, 32'h00010001, 5'd0,  32'h00010000, 1'b0};
    vecs[2]  = '{4'hC, 32'd100,      32'd7,        5'd0,  32'd14,       1'b0};
    vecs[3]  = '{4'hD, 32'd100,      32'd7,        5'd0,  32'd2,        1'b0};
    vecs[4]  = '{4'hC, 32'd5,        32'd0,        5'd0,  32'hFFFFFFFF, 1'b0};
    vecs[5]  = '{4'hD, 32'd5,        32'd0,        5'd0,  32'd5,        1'b0};
    vecs[6]  = '{4'h4, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'd1,        1'b0};
    vecs[7]  = '{4'h8, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'd0,        1'b0};
    vecs[8]  = '{4'h7, 32'h0,        32'h80000000, 5'd4,  32'hF8000000, 1'b0};
    vecs[9]  = '{4'h3, 32'd3,        32'd3,        5'd0,  32'd0,        1'b0};
    vecs[10] = '{4'h3, 32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b1};
    vecs[11] = '{4'h0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0};
    vecs[12] = '{4'h1, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 1'b0};
    vecs[13] = '{4'h9, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h0FF00FF0, 1'b0};
    vecs[14] = '{4'hA, 32'h0,        32'h0,        5'd0,  32'hFFFFFFFF, 1'b0};
    vecs[15] = '{4'h5, 32'hDEADBEEF, 32'h12345678, 5'd0,  32'h12345678, 1'b0};
    vecs[16] = '{4'h6, 32'h0,        32'h80000000, 5'd31, 32'h00000001, 1'b0};
    vecs[17] = '{4'hF, 32'd5,        32'd6,        5'd3,  32'd0,        1'b0};
    vecs[18] = '{4'hE, 32'd5,        32'd6,        5'd3,  32'd0,        1'b0};
    vecs[19] = '{4'hB, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h00000001, 1'b0};

    // Asynchronous reset, then release
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_alu_out", alu_out, 0);
    check("rst_zero", zero, 1);
    check("rst_ovf", ovf, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("in_ready_before_edge", in_ready, 0);
    @(posedge clk); #1;
    check("in_ready_after_release", in_ready, 1);

    // Directed vectors
    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, r, o, z, lat, rb);
      check($sformatf("vec%0d_res", i), r, vecs[i].res);
      check($sformatf("vec%0d_ovf", i), o, vecs[i].ovf);
      check($sformatf("vec%0d_zero", i), z, (vecs[i].res == 0));
      check($sformatf("vec%0d_lat", i), lat, exp_lat(vecs[i].op));
      check($sformatf("vec%0d_busy_ready", i), rb, 0);
      retire();
    end

    // out_ready already high: DONE lasts exactly one cycle
    out_ready = 1'b1;
    do_op(4'h2, 32'd1, 32'd2, 5'd0, r, o, z, lat, rb);
    check("early_ready_res", r, 3);
    check("early_ready_lat", lat, 1);
    @(posedge clk); #1;
    check("early_ready_one_cycle", out_valid, 0);
    out_ready = 1'b0;

    // Backpressure: result held for 10 cycles, then retire and reissue
    do_op(4'h2, 32'h1234, 32'h1111, 5'd0, r, o, z, lat, rb);
    held = r;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (alu_out !== held || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
    end
    check("bp_hold_stable", stable, 1);
    check("bp_held_value", held, 32'h2345);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_retired_valid", out_valid, 0);
    check("bp_retired_ready", in_ready, 1);
    sel = 4'h9; data_1 = 32'hAAAA5555; data_2 = 32'hFFFF0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_reissue_valid", out_valid, 1);
    check("bp_reissue_res", alu_out, 32'h5555_5555);
    retire();

    // Randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom);
      a  = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      b  = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      sh = SW'($urandom);
      model(op, a, b, sh, er, eo);
      do_op(op, a, b, sh, r, o, z, lat, rb);
      check($sformatf("rnd%0d_op%0d_res", i, op), r, er);
      check($sformatf("rnd%0d_op%0d_ovf", i, op), o, eo);
      check($sformatf("rnd%0d_op%0d_zero", i, op), z, (er == 0));
      check($sformatf("rnd%0d_op%0d_lat", i, op), lat, exp_lat(op));
      retire();
    end

    // Reset in cycle 10 of a DIVU aborts it
    do_op(4'h2, 32'd40, 32'd2, 5'd0, r, o, z, lat, rb);
    retire();
    sel = 4'hC; data_1 = 32'd1000; data_2 = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_alu_out", alu_out, 0);
    check("abort_zero", zero, 1);
    check("abort_ovf", ovf, 0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_stale_valid", seen, 0);
    check("abort_ready_after", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
